// File: rtl/subleq_ctrl.sv
// SUBLEQ instruction sequencer: fetch A/B/C, read mem[A]/mem[B], write mem[B]-mem[A], then branch.
// Optional single-step mode via `SUBLEQ_CTRL_STEP_EN` (adds the step input and an IDLE state).

`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module subleq_ctrl #(
    parameter logic [`WORD_SIZE-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef SUBLEQ_CTRL_STEP_EN
    input  logic                  step,
`endif
    output logic                  load,
    output logic [`WORD_SIZE-1:0] addr,
    output logic [`WORD_SIZE-1:0] data_out,
    input  logic [`WORD_SIZE-1:0] data_in,
    input  logic                  halt,
    output logic                  mem_we,
    output logic                  halted,
    output logic [`WORD_SIZE-1:0] pc,
    output logic [31:0]           instr_count
);

    localparam int W = `WORD_SIZE;

    typedef enum logic [2:0] {
        FETCH_A,
        FETCH_B,
        FETCH_C,
        READ_A,
        READ_B,
        WRITE,
        HALTED
`ifdef SUBLEQ_CTRL_STEP_EN
        , IDLE
`endif
    } state_t;

`ifdef SUBLEQ_CTRL_STEP_EN
    localparam state_t RST_STATE = IDLE;
`else
    localparam state_t RST_STATE = FETCH_A;
`endif

    state_t         state, next_state;
    logic [W-1:0]   a, b, c, va, vb;
    logic [W-1:0]   diff;
    logic           taken;
    logic           halt_live;

    assign diff  = vb - va;
    assign taken = diff[W-1] || (diff == '0);

    // IDLE waits for an operator step, so a pending halt there is ignored.
`ifdef SUBLEQ_CTRL_STEP_EN
    assign halt_live = halt && (state != HALTED) && (state != IDLE);
`else
    assign halt_live = halt && (state != HALTED);
`endif

    assign halted = (state == HALTED);

    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        next_state = state;
        addr       = pc;
        load       = 1'b1;
        mem_we     = 1'b0;
        data_out   = '0;
        unique case (state)
            FETCH_A: begin addr = pc;         next_state = FETCH_B; end
            FETCH_B: begin addr = pc + W'(1); next_state = FETCH_C; end
            FETCH_C: begin addr = pc + W'(2); next_state = READ_A;  end
            READ_A:  begin addr = a;          next_state = READ_B;  end
            READ_B:  begin addr = b;          next_state = WRITE;   end
            WRITE: begin
                addr     = b;
                load     = 1'b0;
                data_out = diff;
                mem_we   = !halt;
`ifdef SUBLEQ_CTRL_STEP_EN
                next_state = IDLE;
`else
                next_state = FETCH_A;
`endif
            end
`ifdef SUBLEQ_CTRL_STEP_EN
            IDLE:    if (step) next_state = FETCH_A;
`endif
            default: next_state = state;
        endcase
        if (halt_live) next_state = HALTED;
        // NOTE: reset is synchronous, so the bus is forced quiet combinationally to keep the reset cycle from committing a write.
        if (!rst_n) begin
            load     = 1'b1;
            mem_we   = 1'b0;
            data_out = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= RST_STATE;
        else        state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            instr_count <= '0;
            a           <= '0;
            b           <= '0;
            c           <= '0;
            va          <= '0;
            vb          <= '0;
        end else if (!halt_live) begin
            unique case (state)
                FETCH_A: a  <= data_in;
                FETCH_B: b  <= data_in;
                FETCH_C: c  <= data_in;
                READ_A:  va <= data_in;
                READ_B:  vb <= data_in;
                WRITE: begin
                    pc          <= taken ? c : pc + W'(3);
                    instr_count <= instr_count + 32'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_subleq_ctrl.sv
// Self-checking bench for subleq_ctrl: bench-side memory/decoder plus an instruction-level reference model.
// Builds with or without SUBLEQ_CTRL_STEP_EN.

`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module tb_subleq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        step;
    logic        inject;
    logic        load;
    logic [15:0] addr;
    logic [15:0] data_out;
    logic [15:0] data_in;
    logic        halt;
    logic        mem_we;
    logic        halted;
    logic [15:0] pc;
    logic [31:0] instr_count;

    subleq_ctrl #(.RESET_PC(16'd0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef SUBLEQ_CTRL_STEP_EN
        .step       (step),
`endif
        .load       (load),
        .addr       (addr),
        .data_out   (data_out),
        .data_in    (data_in),
        .halt       (halt),
        .mem_we     (mem_we),
        .halted     (halted),
        .pc         (pc),
        .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // System memory behind the decoder; 0xFFFF is the halt address.
    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];
    int          we_count = 0;

    assign data_in = mem[addr];
    assign halt    = (addr == 16'hFFFF) || inject;

    always @(posedge clk) begin
        if (mem_we) begin
            mem[addr] = data_out;
            we_count++;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    endtask

    // Instruction-level model: the phase counts cycles within the current instruction.
    logic [15:0] m_pc;
    logic [31:0] m_cnt;
    int          m_phase;
    bit          m_halted;
    bit          m_idle;

    task automatic model_cycle();
        logic [15:0] p1, p2, ia, ib, ic, ea, res;
        bit active, hlt, wr;
        p1  = m_pc + 16'd1;
        p2  = m_pc + 16'd2;
        ia  = ref_mem[m_pc];
        ib  = ref_mem[p1];
        ic  = ref_mem[p2];
        res = ref_mem[ib] - ref_mem[ia];
        active = !m_halted && !m_idle;
        case (m_phase)
            0: ea = m_pc;
            1: ea = p1;
            2: ea = p2;
            3: ea = ia;
            default: ea = ib;
        endcase
        if (!active) ea = m_pc;
        hlt = active && ((ea == 16'hFFFF) || inject);
        wr  = active && (m_phase == 5);

        if (!rst_n) begin
            check("rst_load", load, 1'b1);
            check("rst_mem_we", mem_we, 1'b0);
        end else begin
            check("addr", addr, ea);
            check("load", load, !wr);
            check("mem_we", mem_we, wr && !hlt);
            check("data_out", data_out, wr ? res : 16'd0);
            check("halted", halted, m_halted);
            check("pc", pc, m_pc);
            check("instr_count", instr_count, m_cnt);
        end

        if (!rst_n) begin
            m_pc = 16'd0; m_cnt = 0; m_phase = 0; m_halted = 0;
`ifdef SUBLEQ_CTRL_STEP_EN
            m_idle = 1;
`else
            m_idle = 0;
`endif
        end else if (active) begin
            if (hlt) m_halted = 1;
            else if (m_phase == 5) begin
                ref_mem[ib] = res;
                m_pc  = ($signed(res) <= 0) ? ic : m_pc + 16'd3;
                m_cnt = m_cnt + 1;
                m_phase = 0;
`ifdef SUBLEQ_CTRL_STEP_EN
                m_idle = 1;
`endif
            end else m_phase++;
        end else if (m_idle && step) begin
            m_idle = 0;
        end
    endtask

    task automatic tick(input logic r, input logic s, input logic inj);
        @(negedge clk);
        rst_n  = r;
        step   = s;
        inject = inj;
        #1;
        model_cycle();
    endtask

    task automatic ld(input logic [15:0] a, input logic [15:0] v);
        mem[a]     = v;
        ref_mem[a] = v;
    endtask

    // The reset cycle holds mem_we low, so the memories can be rewritten safely afterwards.
    task automatic reset_and_clear();
        tick(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 65536; i++) ld(i[15:0], 16'd0);
    endtask

    task automatic prologue();
`ifdef SUBLEQ_CTRL_STEP_EN
        tick(1'b1, 1'b1, 1'b0);
`endif
    endtask

    task automatic load_basic(input logic [15:0] v10, input logic [15:0] v11);
        reset_and_clear();
        ld(16'd0, 16'd10); ld(16'd1, 16'd11); ld(16'd2, 16'd0);
        ld(16'd10, v10);   ld(16'd11, v11);
    endtask

    task automatic run6();
        prologue();
        repeat (6) tick(1'b1, 1'b0, 1'b0);
    endtask

    int we_start;

    initial begin
        rst_n = 1'b0; step = 1'b0; inject = 1'b0;
        m_pc = 0; m_cnt = 0; m_phase = 0; m_halted = 0; m_idle = 0;

        // Positive result: no branch.
        load_basic(16'd3, 16'd5);
        run6();
        check("s1_wr_addr", addr, 16'd11);
        check("s1_wr_data", data_out, 16'd2);
        check("s1_wr_we", mem_we, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        check("s1_next_addr", addr, 16'd3);
        check("s1_count", instr_count, 32'd1);
        check("s1_mem11", mem[11], 16'd2);

        // Zero result branches.
        load_basic(16'd5, 16'd5);
        run6();
        check("s2_wr_data", data_out, 16'd0);
        tick(1'b1, 1'b0, 1'b0);
        check("s2_next_addr", addr, 16'd0);

        // Negative result branches.
        load_basic(16'd5, 16'd4);
        run6();
        check("s2b_wr_data", data_out, 16'hFFFF);
        tick(1'b1, 1'b0, 1'b0);
        check("s2b_next_addr", addr, 16'd0);

        // Branch to the halt address.
        reset_and_clear();
        ld(16'd0, 16'd12); ld(16'd1, 16'd12); ld(16'd2, 16'hFFFF); ld(16'd12, 16'd7);
        run6();
        check("s3_wr_data", data_out, 16'd0);
        prologue();
        tick(1'b1, 1'b0, 1'b0);
        check("s3_fetch_addr", addr, 16'hFFFF);
        check("s3_halt", halt, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        check("s3_halted", halted, 1'b1);
        check("s3_pc", pc, 16'hFFFF);
        check("s3_count", instr_count, 32'd1);
        check("s3_mem12", mem[12], 16'd0);

        // Halt injected during READ_A.
        load_basic(16'd3, 16'd5);
        we_start = we_count;
        prologue();
        repeat (3) tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        repeat (4) tick(1'b1, 1'b0, 1'b1);
        check("s4_halted", halted, 1'b1);
        check("s4_pc", pc, 16'd0);
        check("s4_count", instr_count, 32'd0);
        check("s4_no_write", we_count - we_start, 0);

        // Reset asserted during WRITE.
        load_basic(16'd3, 16'd5);
        prologue();
        repeat (5) tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("s5_rst_we", mem_we, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        check("s5_addr", addr, 16'd0);
        check("s5_count", instr_count, 32'd0);
        check("s5_mem11", mem[11], 16'd5);

`ifdef SUBLEQ_CTRL_STEP_EN
        // Single-step: idle without step, one pulse = one instruction, step mid-instruction ignored.
        load_basic(16'd3, 16'd5);
        repeat (20) tick(1'b1, 1'b0, 1'b0);
        check("st_idle_addr", addr, 16'd0);
        check("st_idle_count", instr_count, 32'd0);
        tick(1'b1, 1'b1, 1'b0);
        repeat (11) tick(1'b1, 1'b0, 1'b0);
        check("st_one_count", instr_count, 32'd1);
        check("st_one_addr", addr, 16'd3);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        repeat (9) tick(1'b1, 1'b0, 1'b0);
        check("st_fb_count", instr_count, 32'd2);
        check("st_fb_pc", pc, 16'd0);
`endif

        // Randomized programs with random halts, resets and steps.
        for (int round = 0; round < 6; round++) begin
            reset_and_clear();
            for (int i = 0; i < 96; i++)
                ld(i[15:0], ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 95)));
            for (int cyc = 0; cyc < 500; cyc++) begin
                logic r;
                r = ($urandom_range(0, 249) != 0);
                if (m_halted && $urandom_range(0, 3) == 0) r = 1'b0;
                tick(r, 1'($urandom_range(0, 1)), ($urandom_range(0, 79) == 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
